// File: rtl/branch_pc_controller.sv
// Program-counter sequencer in front of the Branch unit.
// Advances the fetch PC, hands each branch/jump to the Branch unit with a
// single-cycle enable, waits RESOLVE_LAT cycles, then redirects (with a
// front-end flush) or falls through. Keeps saturating branch statistics.
module branch_pc_controller #(
    parameter int ADDR_W      = 10,
    parameter int RESET_PC    = 0,
    parameter int INC         = 4,
    parameter int RESOLVE_LAT = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              instr_valid,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_en,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] INC_L      = ADDR_W'(INC);
    localparam logic [3:0]        LAT_L      = 4'(RESOLVE_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] br_pc_q, br_pc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pc_valid_q, pc_valid_d;
    logic              br_en_q, br_en_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;

    // Next-state logic: sequencing, branch hand-off and resolution.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        br_pc_d        = br_pc_q;
        cnt_d          = cnt_q;
        pc_valid_d     = pc_valid_q;
        br_en_d        = 1'b0;
        flush_d        = 1'b0;
        busy_d         = busy_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;

        case (state_q)
            S_IDLE: begin
                // First cycle out of reset only validates the reset PC.
                state_d    = S_RUN;
                pc_valid_d = 1'b1;
            end
            S_RUN: begin
                if (!stall_in) begin
                    if (instr_valid && (is_branch || is_jump)) begin
                        // Branch and jump together still form one request.
                        br_pc_d    = pc_q;
                        br_en_d    = 1'b1;
                        pc_valid_d = 1'b0;
                        busy_d     = 1'b1;
                        cnt_d      = 4'd0;
                        state_d    = S_RESOLVE;
                        if (branch_count_q != CNT_MAX) begin
                            branch_count_d = branch_count_q + 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + INC_L;
                    end
                end
            end
            S_RESOLVE: begin
                // Stall is ignored here so resolution always completes.
                if (cnt_q == LAT_L) begin
                    busy_d     = 1'b0;
                    pc_valid_d = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = S_RUN;
                    if (br_taken) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                        if (taken_count_q != CNT_MAX) begin
                            taken_count_d = taken_count_q + 1'b1;
                        end
                    end else begin
                        pc_d = br_pc_q + INC_L;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC_L;
            br_pc_q        <= '0;
            cnt_q          <= 4'd0;
            pc_valid_q     <= 1'b0;
            br_en_q        <= 1'b0;
            flush_q        <= 1'b0;
            busy_q         <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            br_pc_q        <= br_pc_d;
            cnt_q          <= cnt_d;
            pc_valid_q     <= pc_valid_d;
            br_en_q        <= br_en_d;
            flush_q        <= flush_d;
            busy_q         <= busy_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign br_en        = br_en_q;
    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign flush        = flush_q;
    assign busy         = busy_q;
    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;

endmodule
